// File: rtl/mips32_prog_loader.sv
// Program-image loader for the pipelined MIPS32 core.
// Takes a framed word stream (header, N data words, checksum), writes the
// data into core memory through a dedicated write port, and keeps the core
// halted until the image is complete and its checksum matches.
module mips32_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [31:0]       pc_init,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CHK, S_START, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W+1:0] DEPTH = (CNT_W+2)'(1) << ADDR_W;

  state_t           state, state_nxt;
  logic [1:0]       code_nxt;
  logic             rdy_nxt, hold_nxt, start_nxt, busy_nxt, done_nxt, err_nxt;

  logic [CNT_W-1:0] base_q, n_q;
  logic [CNT_W:0]   cnt_q;
  logic [31:0]      sum_q;

  logic             xfer, start_load, hdr_bad, last_data;
  logic [CNT_W-1:0] hdr_n, hdr_base;
  logic [CNT_W+1:0] hdr_end;
  logic [CNT_W:0]   cnt_inc;

  assign xfer       = in_valid & in_ready;
  assign start_load = load_req & (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign hdr_n      = in_data[31:16];
  assign hdr_base   = in_data[15:0];
  // End address is formed two bits wider than the fields so it can never wrap.
  assign hdr_end    = {2'b00, hdr_base} + {2'b00, hdr_n};
  assign hdr_bad    = (hdr_n == '0) | (hdr_end > DEPTH);
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_data  = (cnt_inc == {1'b0, n_q});

  // State and status outputs; status is registered from the next-state decode.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      err_code  <= 2'd0;
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b1;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_code  <= code_nxt;
      in_ready  <= rdy_nxt;
      cpu_hold  <= hold_nxt;
      cpu_start <= start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Frame sequencing and error classification.
  always_comb begin
    state_nxt = state;
    code_nxt  = err_code;
    if (start_load) begin
      state_nxt = S_HDR;
      code_nxt  = 2'd0;
    end else begin
      case (state)
        S_HDR: if (xfer) begin
          // A bad header outranks a misplaced in_last.
          if (hdr_bad)      begin state_nxt = S_ERR; code_nxt = 2'd1; end
          else if (in_last) begin state_nxt = S_ERR; code_nxt = 2'd2; end
          else                    state_nxt = S_DATA;
        end
        S_DATA: if (xfer) begin
          if (in_last)        begin state_nxt = S_ERR; code_nxt = 2'd2; end
          else if (last_data)       state_nxt = S_CHK;
        end
        S_CHK: if (xfer) begin
          if (!in_last)              begin state_nxt = S_ERR; code_nxt = 2'd2; end
          else if (in_data != sum_q) begin state_nxt = S_ERR; code_nxt = 2'd3; end
          else                             state_nxt = S_START;
        end
        S_START: state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Status for the coming cycle, decoded from the next state.
  always_comb begin
    rdy_nxt   = (state_nxt == S_HDR) || (state_nxt == S_DATA) || (state_nxt == S_CHK);
    busy_nxt  = rdy_nxt;
    hold_nxt  = !((state_nxt == S_START) || (state_nxt == S_DONE));
    start_nxt = (state_nxt == S_START);
    done_nxt  = (state_nxt == S_START) || (state_nxt == S_DONE);
    err_nxt   = (state_nxt == S_ERR);
  end

  // Datapath: header latch, word counter, running checksum, write port, start PC.
  always_ff @(posedge clk1) begin
    if (rst) begin
      base_q    <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc_init   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_load) sum_q <= '0;
      case (state)
        S_HDR: if (xfer && !hdr_bad && !in_last) begin
          base_q <= hdr_base;
          n_q    <= hdr_n;
          cnt_q  <= '0;
        end
        S_DATA: if (xfer) begin
          // The word carrying a stray in_last is still written.
          mem_we    <= 1'b1;
          mem_addr  <= base_q[ADDR_W-1:0] + cnt_q[ADDR_W-1:0];
          mem_wdata <= in_data;
          sum_q     <= sum_q + in_data;
          cnt_q     <= cnt_inc;
        end
        S_CHK: if (xfer && in_last && (in_data == sum_q))
          pc_init <= {{(32-CNT_W){1'b0}}, base_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: frame-level reference model feeds a scoreboard
// of expected memory writes and start PCs; an independent monitor drains it.
module tb_mips32_prog_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst, load_req, in_valid, in_last;
  logic [31:0]       in_data;
  logic              in_ready, mem_we, cpu_hold, cpu_start, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, pc_init;
  logic [1:0]        err_code;

  mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1(clk1), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .pc_init(pc_init),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk1 = ~clk1;

  typedef struct { int unsigned addr; logic [31:0] data; } wr_t;
  wr_t         exp_wr[$];
  int unsigned exp_pc[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] fw[$];
  bit          fl[$];
  int          m_acc;
  bit          m_ok;
  logic [1:0]  m_code;
  logic [31:0] m_pc;

  logic [31:0] nom [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                           32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Frame semantics: how many words are taken, which writes happen, outcome.
  function automatic void model();
    int unsigned n = fw[0][31:16];
    int unsigned b = fw[0][15:0];
    logic [31:0] s = 32'd0;
    m_ok = 1'b0;
    m_pc = 32'd0;
    if (n == 0 || b + n > DEPTH) begin m_code = 2'd1; m_acc = 1; return; end
    if (fl[0]) begin m_code = 2'd2; m_acc = 1; return; end
    for (int i = 1; i <= int'(n); i++) begin
      exp_wr.push_back('{b + i - 1, fw[i]});
      s += fw[i];
      if (fl[i]) begin m_code = 2'd2; m_acc = i + 1; return; end
    end
    m_acc = n + 2;
    if (!fl[n+1])          m_code = 2'd2;
    else if (fw[n+1] != s) m_code = 2'd3;
    else begin
      m_code = 2'd0; m_ok = 1'b1; m_pc = b;
      exp_pc.push_back(b);
    end
  endfunction

  // Monitor: every write and start pulse must match the head of its queue.
  always @(negedge clk1) begin
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h required=none", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
    if (cpu_start) begin
      if (exp_pc.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start pc=%h required=none", pc_init);
      end else begin
        int unsigned p;
        p = exp_pc.pop_front();
        chk("start_pc", pc_init, p);
        chk("start_hold", 32'(cpu_hold), 32'd0);
      end
    end
  end

  task automatic pulse_load();
    @(negedge clk1); load_req = 1'b1;
    @(negedge clk1); load_req = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    chk("load_flags", {30'd0, done, err}, 32'd0);
    chk("load_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] w, input bit last, input bit gaps);
    bit got = 1'b0;
    int t = 0;
    while (!got && t < 200) begin
      @(negedge clk1);
      t++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        got      = in_ready;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h ready=%b required_ready=1", w, in_ready);
    end
  endtask

  task automatic run_frame(input bit gaps);
    model();
    pulse_load();
    for (int i = 0; i < m_acc; i++) send(fw[i], fl[i], gaps);
    @(negedge clk1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("ready_drop", 32'(in_ready), 32'd0);
    @(negedge clk1);
    chk("done", 32'(done), 32'(m_ok));
    chk("err", 32'(err), 32'(!m_ok));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("hold", 32'(cpu_hold), 32'(!m_ok));
    chk("busy_end", 32'(busy), 32'd0);
    if (m_ok) chk("pc_init", pc_init, m_pc);
    chk("wr_drain", exp_wr.size(), 32'd0);
    chk("pc_drain", exp_pc.size(), 32'd0);
  endtask

  task automatic set_nominal(input logic [31:0] cs);
    fw.delete(); fl.delete();
    fw.push_back(32'h00080000); fl.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin fw.push_back(nom[i]); fl.push_back(1'b0); end
    fw.push_back(cs); fl.push_back(1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_start", 32'(cpu_start), 32'd0);
    chk("rst_pc", pc_init, 32'd0);
    chk("rst_flags", {28'd0, busy, done, err, 1'b0}, 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(negedge clk1);
    check_reset_outputs();
    rst = 1'b0;

    // nominal image
    set_nominal(32'hB5B048A6);
    run_frame(1'b0);
    // checksum off by one: all writes happen, core stays halted
    set_nominal(32'hB5B048A7);
    run_frame(1'b0);
    // empty frame and an out-of-range frame
    set_nominal(32'hB5B048A6); fw[0] = 32'h00000010;
    run_frame(1'b0);
    set_nominal(32'hB5B048A6); fw[0] = 32'h000803FC;
    run_frame(1'b0);
    // in_last on the second data word
    fw.delete(); fl.delete();
    fw = '{32'h00030078, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66666666};
    fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_frame(1'b0);
    // last word of memory, with stalls, then a reload
    fw = '{32'h000103FF, 32'd85, 32'd85};
    fl = '{1'b0, 1'b0, 1'b1};
    run_frame(1'b1);
    set_nominal(32'hB5B048A6);
    run_frame(1'b1);

    // reset after four data words; a fifth word is presented alongside rst
    set_nominal(32'hB5B048A6);
    for (int i = 0; i < 4; i++) exp_wr.push_back('{i, nom[i]});
    pulse_load();
    for (int i = 0; i < 5; i++) send(fw[i], fl[i], 1'b0);
    @(negedge clk1);
    in_valid = 1'b1; in_data = nom[4]; in_last = 1'b0; rst = 1'b1; load_req = 1'b1;
    @(negedge clk1);
    rst = 1'b0; load_req = 1'b0; in_valid = 1'b0;
    check_reset_outputs();
    chk("rst_drain", exp_wr.size(), 32'd0);
    set_nominal(32'hB5B048A6);
    run_frame(1'b0);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      int unsigned n, b;
      logic [31:0] s;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      b = ($urandom_range(0, 3) == 0) ? (DEPTH - n + $urandom_range(0, 1)) : $urandom_range(0, DEPTH - 7);
      fw.delete(); fl.delete();
      fw.push_back({16'(n), 16'(b)}); fl.push_back(1'b0);
      s = 32'd0;
      for (int i = 0; i < int'(n); i++) begin
        logic [31:0] d;
        d = $urandom;
        s += d;
        fw.push_back(d); fl.push_back(1'b0);
      end
      fw.push_back(($urandom_range(0, 4) == 0) ? s + 32'd1 : s); fl.push_back(1'b1);
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(0, fl.size() - 1);
        fl[k] = !fl[k];
      end
      run_frame(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
